ghost_cmd_parser: RTL

//  Framed command decoder between the UART receiver and the Ghostbox output drivers.

---
 rtl/ghost_cmd_parser_pkg.sv | 30 +++
 rtl/ghost_cmd_parser_byte_timeout.sv | 30 +++
 rtl/ghost_cmd_parser.sv | 94 +++++++++
 3 files changed

// File: rtl/ghost_cmd_parser_pkg.sv
// Shared definitions for the Ghostbox command parser.
// Holds the frame constants, state encoding and command legality check.
package ghost_cmd_parser_pkg;

    localparam logic [7:0] SYNC_DEFAULT   = 8'hA5;
    localparam logic [7:0] CMD_SEVSEG     = 8'h01;
    localparam logic [7:0] CMD_BUZZ       = 8'h02;
    localparam logic [7:0] CMD_SEVSEG_RST = 8'h03;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    function automatic logic frame_legal(input logic [7:0] cmd,
                                         input logic [7:0] data);
        logic ok;
        ok = 1'b0;
        unique case (1'b1)
            (cmd == CMD_SEVSEG),
            (cmd == CMD_SEVSEG_RST): ok = 1'b1;
            (cmd == CMD_BUZZ):       ok = (data[7:4] == 4'd0) && (data[3:0] != 4'd0);
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ghost_cmd_parser_byte_timeout.sv
// Inter-byte watchdog for the command parser.
// Saturating counter; expiry is suppressed when a byte arrives that cycle.
module byte_timeout
    import ghost_cmd_parser_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    input  logic i_kick,
    output logic o_expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_kick || !i_run) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_expired = i_run && !i_kick && (cnt == LAST);

endmodule

// File: rtl/ghost_cmd_parser.sv
// Framed SYNC/CMD/DATA/CHK decoder driving the seven-segment and buzzer.
// Every output is a flop; rejects and timeouts pulse o_err.
module ghost_cmd_parser
    import ghost_cmd_parser_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 250000,
    parameter logic [3:0] BUZZ_RST       = 4'd1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_dv,
    input  logic [7:0] i_rx_byte,
    output logic [7:0] o_sevseg_num,
    output logic [3:0] o_buzz_freq,
    output logic       o_cmd_valid,
    output logic       o_err,
    output logic       o_busy
);

    state_t     state;
    logic [7:0] cmd;
    logic [7:0] data;
    logic       expired;

    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_run    (state != S_SYNC),
        .i_kick   (i_rx_dv),
        .o_expired(expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_SYNC;
            cmd          <= '0;
            data         <= '0;
            o_sevseg_num <= '0;
            o_buzz_freq  <= BUZZ_RST;
            o_cmd_valid  <= 1'b0;
            o_err        <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_cmd_valid <= 1'b0;
            o_err       <= 1'b0;
            if (i_rx_dv) begin
                unique case (state)
                    S_SYNC: begin
                        if (i_rx_byte == SYNC_BYTE) begin
                            state  <= S_CMD;
                            o_busy <= 1'b1;
                        end
                    end
                    S_CMD: begin
                        cmd   <= i_rx_byte;
                        state <= S_DATA;
                    end
                    S_DATA: begin
                        data  <= i_rx_byte;
                        state <= S_CHK;
                    end
                    S_CHK: begin
                        state  <= S_SYNC;
                        o_busy <= 1'b0;
                        if (i_rx_byte == (cmd ^ data) && frame_legal(cmd, data)) begin
                            o_cmd_valid <= 1'b1;
                            case (cmd)
                                CMD_SEVSEG: o_sevseg_num <= data;
                                CMD_BUZZ:   o_buzz_freq  <= data[3:0];
                                CMD_SEVSEG_RST: begin
                                    o_sevseg_num <= data;
                                    o_buzz_freq  <= BUZZ_RST;
                                end
                                default: ;
                            endcase
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                    default: state <= S_SYNC;
                endcase
            end else if (expired) begin
                // A stalled frame is abandoned; the next byte must be SYNC again.
                state  <= S_SYNC;
                o_busy <= 1'b0;
                o_err  <= 1'b1;
            end
        end
    end

endmodule
